// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: register-address width, hazard-controller FSM
// states and the bundled per-stage load/flush controls.
package rv32i_types;

    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } hazard_state_t;

    typedef struct packed {
        logic load_pc;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
    } stage_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the ID instruction reads a register that
// the load currently in EX has not yet produced.
module load_use_detect
    import rv32i_types::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign hazard = ex_is_load && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencing: merges memory waits, load-use stalls and
// branch redirects into per-stage enables; adds a freeze watchdog and counters.
module pipeline_hazard_ctrl
    import rv32i_types::*;
#(
    parameter int FREEZE_TIMEOUT = 256,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_resp,
    input  logic                  dmem_op_mem,
    input  logic                  dmem_resp,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    output logic                  load_pc,
    output logic                  load_if_id,
    output logic                  load_id_ex,
    output logic                  load_ex_mem,
    output logic                  load_mem_wb,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  freeze_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int FL_W = $clog2(FREEZE_TIMEOUT) + 1;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [FL_W-1:0] sat_inc_len(input logic [FL_W-1:0] v);
        return (&v) ? v : v + FL_W'(1);
    endfunction

    hazard_state_t state_q, state_d;
    stage_ctrl_t   ctrl;
    logic          freeze_req;
    logic          load_use;
    logic          stall_evt;
    logic          flush_evt;
    logic [FL_W-1:0] freeze_len;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .hazard      (load_use)
    );

    assign freeze_req = !imem_resp || (dmem_op_mem && !dmem_resp);

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (freeze_req)  state_d = FREEZE;
            FREEZE:  if (!freeze_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Priority encoder: reset, freeze, branch redirect, load-use, normal flow
    always_comb begin
        ctrl      = '0;
        stall_evt = 1'b0;
        flush_evt = 1'b0;
        if (rst) begin
            ctrl = '0;
        end else if (freeze_req) begin
            stall_evt = 1'b1;
        end else if (ex_branch_taken) begin
            // Wrong-path ID instruction is squashed, so any load-use on it is moot
            ctrl      = '1;
            flush_evt = 1'b1;
        end else if (load_use) begin
            ctrl.load_id_ex  = 1'b1;
            ctrl.flush_id_ex = 1'b1;
            ctrl.load_ex_mem = 1'b1;
            ctrl.load_mem_wb = 1'b1;
            stall_evt        = 1'b1;
        end else begin
            ctrl.load_pc     = 1'b1;
            ctrl.load_if_id  = 1'b1;
            ctrl.load_id_ex  = 1'b1;
            ctrl.load_ex_mem = 1'b1;
            ctrl.load_mem_wb = 1'b1;
        end
    end

    assign load_pc     = ctrl.load_pc;
    assign load_if_id  = ctrl.load_if_id;
    assign load_id_ex  = ctrl.load_id_ex;
    assign load_ex_mem = ctrl.load_ex_mem;
    assign load_mem_wb = ctrl.load_mem_wb;
    assign flush_if_id = ctrl.flush_if_id;
    assign flush_id_ex = ctrl.flush_id_ex;

    // Watchdog counts every frozen cycle, including the one that leaves RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            freeze_len     <= '0;
            freeze_timeout <= 1'b0;
        end else begin
            if (freeze_req)
                freeze_len <= sat_inc_len(freeze_len);
            else if (state_q == FREEZE)
                freeze_len <= '0;
            if (freeze_req && (freeze_len == FL_W'(FREEZE_TIMEOUT - 1)))
                freeze_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt) stall_cnt <= sat_inc_cnt(stall_cnt);
            if (flush_evt) flush_cnt <= sat_inc_cnt(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: fixed vector table, directed multi-cycle
// sequences and randomized traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int FT    = 256;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic imem_resp, dmem_op_mem, dmem_resp;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, flush_id_ex, freeze_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_stall = 0;
    int m_flush = 0;
    int m_frun  = 0;
    bit m_to    = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FREEZE_TIMEOUT(FT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .imem_resp(imem_resp), .dmem_op_mem(dmem_op_mem), .dmem_resp(dmem_resp),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .freeze_timeout(freeze_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic       imem, dop, dresp;
        logic [4:0] rs1, rs2;
        logic       u1, u2, exl;
        logic [4:0] exrd;
        logic       br;
        logic [6:0] exp;   // {load_pc,if_id,id_ex,ex_mem,mem_wb,flush_if_id,flush_id_ex}
    } vec_t;

    vec_t vecs[11];

    function automatic logic [6:0] dut_ctrl();
        return {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                flush_if_id, flush_id_ex};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        imem_resp = 1; dmem_op_mem = 0; dmem_resp = 0;
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_is_load = 0; ex_rd = 0; ex_branch_taken = 0;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model,
    // then check the registered state just after the edge.
    task automatic cycle(input string nm);
        bit frz, lu;
        logic [6:0] exp;
        @(negedge clk);
        frz = !imem_resp || (dmem_op_mem && !dmem_resp);
        lu  = ex_is_load && ex_rd != 0 &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (rst || frz)           exp = 7'b00000_00;
        else if (ex_branch_taken) exp = 7'b11111_11;
        else if (lu)              exp = 7'b00111_01;
        else                      exp = 7'b11111_00;
        check({nm, ".ctrl"}, 64'(dut_ctrl()), 64'(exp));
        if (rst) begin
            m_stall = 0; m_flush = 0; m_frun = 0; m_to = 0;
        end else if (frz) begin
            m_stall++;
            m_frun++;
            if (m_frun >= FT) m_to = 1;
        end else begin
            m_frun = 0;
            if (ex_branch_taken) m_flush++;
            else if (lu)         m_stall++;
        end
        @(posedge clk);
        #1;
        check({nm, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        check({nm, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
        check({nm, ".timeout"},   64'(freeze_timeout), 64'(m_to));
    endtask

    initial begin
        int s0, f0;
        vecs[0]  = '{1,0,0, 0,0, 0,0,0, 0, 0, 7'b11111_00};
        vecs[1]  = '{1,0,0, 0,5, 0,1,1, 5, 0, 7'b00111_01};
        vecs[2]  = '{1,0,0, 0,0, 0,1,1, 0, 0, 7'b11111_00};
        vecs[3]  = '{1,0,0, 7,0, 1,0,1, 7, 0, 7'b00111_01};
        vecs[4]  = '{1,0,0, 7,0, 0,0,1, 7, 0, 7'b11111_00};
        vecs[5]  = '{1,0,0, 7,7, 1,1,0, 7, 0, 7'b11111_00};
        vecs[6]  = '{1,0,0, 0,5, 0,1,1, 5, 1, 7'b11111_11};
        vecs[7]  = '{0,0,0, 0,5, 0,1,1, 5, 1, 7'b00000_00};
        vecs[8]  = '{1,1,0, 0,0, 0,0,0, 0, 1, 7'b00000_00};
        vecs[9]  = '{1,1,1, 0,0, 0,0,0, 0, 1, 7'b11111_11};
        vecs[10] = '{1,0,0, 3,9, 1,1,1, 9, 0, 7'b00111_01};

        rst = 1;
        set_idle();
        cycle("reset0");
        cycle("reset1");
        rst = 0;

        for (int i = 0; i < 10; i++) cycle("idle");
        check("idle.stall_zero", 64'(stall_cnt), 64'd0);

        for (int i = 0; i < 11; i++) begin
            imem_resp = vecs[i].imem; dmem_op_mem = vecs[i].dop; dmem_resp = vecs[i].dresp;
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_is_load = vecs[i].exl; ex_rd = vecs[i].exrd; ex_branch_taken = vecs[i].br;
            #1;
            check($sformatf("vec%0d", i), 64'(dut_ctrl()), 64'(vecs[i].exp));
            cycle($sformatf("vec%0d", i));
        end
        set_idle();
        cycle("idle2");

        // Branch held across a 3-cycle dmem wait, serviced on release
        s0 = int'(stall_cnt); f0 = int'(flush_cnt);
        dmem_op_mem = 1; dmem_resp = 0; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) cycle("dwait_br");
        dmem_resp = 1;
        #1;
        check("dwait_br.release", 64'(dut_ctrl()), 64'h7F);
        cycle("dwait_br_rel");
        check("dwait_br.stall_delta", 64'(int'(stall_cnt) - s0), 64'd3);
        check("dwait_br.flush_delta", 64'(int'(flush_cnt) - f0), 64'd1);
        set_idle();
        cycle("idle3");

        // Back-to-back imem and dmem waits, then watchdog timeout
        imem_resp = 0;
        for (int i = 0; i < FT - 1; i++) cycle("freeze");
        check("freeze.pre_timeout", 64'(freeze_timeout), 64'd0);
        imem_resp = 1; dmem_op_mem = 1; dmem_resp = 0;
        cycle("freeze_last");
        check("freeze.timeout_set", 64'(freeze_timeout), 64'd1);
        set_idle();
        for (int i = 0; i < 3; i++) cycle("post_timeout");
        check("timeout.sticky", 64'(freeze_timeout), 64'd1);

        // Reset in the middle of a 5-cycle dmem wait
        dmem_op_mem = 1; dmem_resp = 0;
        cycle("rst_wait0");
        cycle("rst_wait1");
        rst = 1;
        cycle("rst_wait_rst");
        check("rst.stall_zero", 64'(stall_cnt), 64'd0);
        check("rst.timeout_clr", 64'(freeze_timeout), 64'd0);
        rst = 0;
        cycle("rst_wait3");
        cycle("rst_wait4");
        set_idle();
        cycle("rst_done");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            imem_resp = ($urandom % 8) != 0;
            dmem_op_mem = ($urandom % 3) == 0;
            dmem_resp = ($urandom % 3) != 0;
            id_rs1 = 5'($urandom % 4); id_rs2 = 5'($urandom % 4);
            id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
            ex_is_load = 1'($urandom); ex_rd = 5'($urandom % 4);
            ex_branch_taken = ($urandom % 6) == 0;
            rst = ($urandom % 97) == 0;
            cycle("rand");
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
